// File: rtl/mem_pkg.sv
// Shared types and constants for the video/processor memory subsystem.
package mem_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 15;

  // Fill engine states: idle (processor owns port B) or filling (engine owns port B).
  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } fill_state_e;

  // Byte-enable width for a given data width.
  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dp_bram.sv
// Inferred true dual-port RAM: port A read-only, port B byte-enable write or read.
// Both read ports are read-first and have registered outputs that hold when not read.
module dp_bram
  import mem_pkg::*;
#(
  parameter int unsigned DataW = DefDataW,
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // Port A
  input  logic                          a_en_i,
  input  logic                          a_clr_i,
  input  logic [IdxW-1:0]               a_idx_i,
  output logic [DataW-1:0]              a_rdata_o,
  // Port B
  input  logic                          b_we_i,
  input  logic [be_width(DataW)-1:0]    b_be_i,
  input  logic                          b_re_i,
  input  logic                          b_clr_i,
  input  logic [IdxW-1:0]               b_idx_i,
  input  logic [DataW-1:0]              b_wdata_i,
  output logic [DataW-1:0]              b_rdata_o
);

  localparam int unsigned BeW = be_width(DataW);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] a_rdata_q;
  logic [DataW-1:0] b_rdata_q;

  // Port B byte-lane writes; array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (b_we_i) begin
      for (int i = 0; i < BeW; i++) begin
        if (b_be_i[i]) begin
          mem_q[b_idx_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // Port A output register; clear forces zero for out-of-range reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_q <= '0;
    end else if (a_en_i) begin
      a_rdata_q <= a_clr_i ? '0 : mem_q[a_idx_i];
    end
  end

  // Port B output register; only reads update it so data holds across writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_rdata_q <= '0;
    end else if (b_re_i) begin
      b_rdata_q <= b_clr_i ? '0 : mem_q[b_idx_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/vga_proc_mem.sv
// Display/processor frame buffer: handshakes, range checks and fill engine around dp_bram.
// Optional feature macro: MEM_COLLISION_BYPASS_EN forwards a same-cycle port B write to a
// same-address display read; without it the display read is read-first.
module vga_proc_mem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        vga_en_i,
  input  logic [ADDR_W-1:0]           vga_addr_i,
  output logic                        vga_valid_o,
  output logic [DATA_W-1:0]           vga_data_o,
  input  logic                        proc_req_i,
  input  logic                        proc_we_i,
  input  logic [be_width(DATA_W)-1:0] proc_be_i,
  input  logic [ADDR_W-1:0]           proc_addr_i,
  input  logic [DATA_W-1:0]           proc_wdata_i,
  output logic                        proc_gnt_o,
  output logic                        proc_rvalid_o,
  output logic [DATA_W-1:0]           proc_rdata_o,
  output logic                        proc_err_o,
  input  logic                        fill_start_i,
  input  logic [DATA_W-1:0]           fill_value_i,
  output logic                        fill_busy_o
);

  localparam int unsigned BE_W = be_width(DATA_W);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  fill_state_e       state_q;
  logic [IdxW-1:0]   cnt_q;
  logic [DATA_W-1:0] fill_val_q;

  logic              fill_busy;
  logic              gnt;
  logic              v_oor, p_oor;
  logic [IdxW-1:0]   a_idx;
  logic              b_we, b_re;
  logic [BE_W-1:0]   b_be;
  logic [IdxW-1:0]   b_idx;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] a_rdata;

  logic vga_valid_d, vga_valid_q;
  logic rvalid_d, rvalid_q;
  logic err_d, err_q;

  assign fill_busy = (state_q == StFill);
  // A fill request in the same idle cycle takes priority over the processor.
  assign gnt       = proc_req_i & (state_q == StIdle) & ~fill_start_i;

  assign v_oor = (32'(vga_addr_i) >= DEPTH);
  assign p_oor = (32'(proc_addr_i) >= DEPTH);
  assign a_idx = vga_addr_i[IdxW-1:0];

  // Port B mux: fill engine owns the port while busy.
  always_comb begin
    b_we    = gnt & proc_we_i & ~p_oor;
    b_re    = gnt & ~proc_we_i;
    b_be    = proc_be_i;
    b_idx   = proc_addr_i[IdxW-1:0];
    b_wdata = proc_wdata_i;
    if (fill_busy) begin
      b_we    = 1'b1;
      b_be    = {BE_W{1'b1}};
      b_idx   = cnt_q;
      b_wdata = fill_val_q;
    end
  end

  // Fill FSM: one word per cycle from index 0 up to DEPTH-1, then back to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fill_val_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fill_start_i) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            fill_val_q <= fill_value_i;
          end
        end
        StFill: begin
          if (cnt_q == LastIdx) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Response flag next-state.
  always_comb begin
    vga_valid_d = vga_en_i;
    rvalid_d    = gnt & ~proc_we_i;
    err_d       = gnt & p_oor;
  end

  // Response flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vga_valid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      vga_valid_q <= vga_valid_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  dp_bram #(
    .DataW (DATA_W),
    .Depth (DEPTH),
    .IdxW  (IdxW)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a_en_i    (vga_en_i),
    .a_clr_i   (v_oor),
    .a_idx_i   (a_idx),
    .a_rdata_o (a_rdata),
    .b_we_i    (b_we),
    .b_be_i    (b_be),
    .b_re_i    (b_re),
    .b_clr_i   (p_oor),
    .b_idx_i   (b_idx),
    .b_wdata_i (b_wdata),
    .b_rdata_o (proc_rdata_o)
  );

`ifdef MEM_COLLISION_BYPASS_EN
  logic              coll_d, coll_q;
  logic [DATA_W-1:0] byp_wdata_q;
  logic [BE_W-1:0]   byp_be_q;
  logic [DATA_W-1:0] vga_merged;

  assign coll_d = vga_en_i & ~v_oor & b_we & (a_idx == b_idx);

  // Capture the colliding write; only display reads update it so the output holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coll_q      <= 1'b0;
      byp_wdata_q <= '0;
      byp_be_q    <= '0;
    end else if (vga_en_i) begin
      coll_q <= coll_d;
      if (coll_d) begin
        byp_wdata_q <= b_wdata;
        byp_be_q    <= b_be;
      end
    end
  end

  // Merge written byte lanes over the read-first word.
  always_comb begin
    vga_merged = a_rdata;
    if (coll_q) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byp_be_q[i]) begin
          vga_merged[i*8 +: 8] = byp_wdata_q[i*8 +: 8];
        end
      end
    end
  end

  assign vga_data_o = vga_merged;
`else
  assign vga_data_o = a_rdata;
`endif

  assign vga_valid_o   = vga_valid_q;
  assign proc_gnt_o    = gnt;
  assign proc_rvalid_o = rvalid_q;
  assign proc_err_o    = err_q;
  assign fill_busy_o   = fill_busy;

endmodule

// File: tb/tb_vga_proc_mem.sv
// Self-checking bench for vga_proc_mem with DEPTH=1024 (out-of-range addresses reachable).
module tb_vga_proc_mem;

  localparam int DW  = 16;
  localparam int AW  = 15;
  localparam int DEP = 1024;
`ifdef MEM_COLLISION_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_en;
  logic [AW-1:0] vga_addr;
  logic          vga_valid;
  logic [DW-1:0] vga_data;
  logic          proc_req, proc_we;
  logic [1:0]    proc_be;
  logic [AW-1:0] proc_addr;
  logic [DW-1:0] proc_wdata;
  logic          proc_gnt, proc_rvalid, proc_err;
  logic [DW-1:0] proc_rdata;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;

  always #5 clk = ~clk;

  vga_proc_mem #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEP)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .vga_en_i      (vga_en),
    .vga_addr_i    (vga_addr),
    .vga_valid_o   (vga_valid),
    .vga_data_o    (vga_data),
    .proc_req_i    (proc_req),
    .proc_we_i     (proc_we),
    .proc_be_i     (proc_be),
    .proc_addr_i   (proc_addr),
    .proc_wdata_i  (proc_wdata),
    .proc_gnt_o    (proc_gnt),
    .proc_rvalid_o (proc_rvalid),
    .proc_rdata_o  (proc_rdata),
    .proc_err_o    (proc_err),
    .fill_start_i  (fill_start),
    .fill_value_i  (fill_value),
    .fill_busy_o   (fill_busy)
  );

  typedef struct {
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] model [DEP];
  vec_t          vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 2; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'(DEP + $urandom_range(0, 2000));
    return AW'($urandom_range(0, 63));
  endfunction

  task automatic idle_inputs();
    vga_en = 0; vga_addr = '0; proc_req = 0; proc_we = 0; proc_be = '0;
    proc_addr = '0; proc_wdata = '0; fill_start = 0; fill_value = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vga_valid"}, 32'(vga_valid), 0);
    chk({tag, "_vga_data"}, 32'(vga_data), 0);
    chk({tag, "_gnt"}, 32'(proc_gnt), 0);
    chk({tag, "_rvalid"}, 32'(proc_rvalid), 0);
    chk({tag, "_rdata"}, 32'(proc_rdata), 0);
    chk({tag, "_err"}, 32'(proc_err), 0);
    chk({tag, "_busy"}, 32'(fill_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            busy_cnt, gnt_during, sweep_bad;
    bit            done;
    logic          e_vv, e_rv, e_err;
    logic [DW-1:0] exp_vd, exp_rd;
    logic [AW-1:0] ra [4];

    vecs[0] = '{1'b1, 2'b11, 15'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 2'b00, 15'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 2'b10, 15'h0010, 16'h12AB, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 2'b00, 15'h0010, 16'h0000, 1'b1, 16'h12EF, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 15'h0400, 16'hDEAD, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 2'b00, 15'h0400, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 2'b00, 15'h0000, 16'h0000, 1'b1, 16'h0020, 1'b0};
    vecs[7] = '{1'b1, 2'b01, 15'h0011, 16'h3456, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 2'b00, 15'h0011, 16'h0000, 1'b1, 16'h0056, 1'b0};

    // Reset values
    rst_n = 0;
    idle_inputs();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // Fill with 0x0020; a read is held pending and a second fill_start is ignored
    @(negedge clk);
    fill_start = 1; fill_value = 16'h0020;
    proc_req = 1; proc_we = 0; proc_addr = 15'd5;
    #1 chk("fill_wins_over_req", 32'(proc_gnt), 0);
    busy_cnt = 0; gnt_during = 0; done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (fill_busy) begin
        busy_cnt++;
        if (proc_gnt) gnt_during++;
        fill_start = (busy_cnt == 10);
        if (busy_cnt == 10) fill_value = 16'h9999;
      end else begin
        done = 1;
      end
    end
    chk("fill_finished", 32'(done), 1);
    chk("fill_busy_cycles", 32'(busy_cnt), DEP);
    chk("gnt_during_fill", 32'(gnt_during), 0);
    chk("gnt_after_fill", 32'(proc_gnt), 1);
    @(negedge clk);
    proc_req = 0;
    chk("pending_rvalid", 32'(proc_rvalid), 1);
    chk("pending_rdata", 32'(proc_rdata), 32'h0020);
    for (int i = 0; i < DEP; i++) model[i] = 16'h0020;

    // Display sweep of the whole buffer, pipelined one address per cycle
    sweep_bad = 0;
    for (int i = 0; i <= DEP; i++) begin
      @(negedge clk);
      if (i > 0 && (vga_valid !== 1'b1 || vga_data !== model[i-1])) sweep_bad++;
      if (i < DEP) begin vga_en = 1; vga_addr = AW'(i); end
      else vga_en = 0;
    end
    chk("vga_sweep_errors", 32'(sweep_bad), 0);

    // Directed processor vectors, back to back
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d_rvalid", i - 1), 32'(proc_rvalid), 32'(vecs[i-1].exp_rvalid));
        chk($sformatf("vec%0d_err", i - 1), 32'(proc_err), 32'(vecs[i-1].exp_err));
        if (vecs[i-1].exp_rvalid)
          chk($sformatf("vec%0d_rdata", i - 1), 32'(proc_rdata), 32'(vecs[i-1].exp_rdata));
      end
      if (i < 9) begin
        proc_req = 1; proc_we = vecs[i].we; proc_be = vecs[i].be;
        proc_addr = vecs[i].addr; proc_wdata = vecs[i].wdata;
        #1 chk($sformatf("vec%0d_gnt", i), 32'(proc_gnt), 1);
        if (vecs[i].we && vecs[i].addr < DEP)
          model[vecs[i].addr[9:0]] = merge(model[vecs[i].addr[9:0]], vecs[i].wdata, vecs[i].be);
      end else begin
        proc_req = 0;
      end
    end

    // Same-address display read and processor write in one cycle
    @(negedge clk);
    vga_en = 1; vga_addr = 15'h0020;
    proc_req = 1; proc_we = 1; proc_be = 2'b11; proc_addr = 15'h0020; proc_wdata = 16'hA5A5;
    exp_vd = Bypass ? 16'hA5A5 : model[10'h020];
    model[10'h020] = 16'hA5A5;
    @(negedge clk);
    vga_en = 0; proc_req = 0;
    chk("collision_vga_data", 32'(vga_data), 32'(exp_vd));
    @(negedge clk);
    chk("collision_hold", 32'(vga_data), 32'(exp_vd));
    chk("collision_valid_low", 32'(vga_valid), 0);

    // Randomized traffic on both ports against the array model
    exp_rd = '0; e_vv = 0; e_rv = 0; e_err = 0;
    for (int c = 0; c <= 400; c++) begin
      logic          ven, req, we;
      logic [1:0]    be;
      logic [AW-1:0] vad, pad;
      logic [DW-1:0] wd;
      @(negedge clk);
      if (c > 0) begin
        chk("rnd_vga_valid", 32'(vga_valid), 32'(e_vv));
        chk("rnd_vga_data", 32'(vga_data), 32'(exp_vd));
        chk("rnd_rvalid", 32'(proc_rvalid), 32'(e_rv));
        chk("rnd_rdata", 32'(proc_rdata), 32'(exp_rd));
        chk("rnd_err", 32'(proc_err), 32'(e_err));
      end
      if (c == 400) begin
        idle_inputs();
      end else begin
        ven = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        req = (c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        we  = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        be  = 2'($urandom_range(0, 3));
        vad = rand_addr();
        pad = (ven && $urandom_range(0, 3) == 0) ? vad : rand_addr();
        wd  = 16'($urandom);
        vga_en = ven; vga_addr = vad;
        proc_req = req; proc_we = we; proc_be = be; proc_addr = pad; proc_wdata = wd;
        #1 chk("rnd_gnt", 32'(proc_gnt), 32'(req));
        e_vv = ven;
        if (ven) begin
          if (vad >= DEP) exp_vd = '0;
          else if (Bypass && req && we && pad == vad) exp_vd = merge(model[vad[9:0]], wd, be);
          else exp_vd = model[vad[9:0]];
        end
        e_rv  = req && !we;
        if (e_rv) exp_rd = (pad >= DEP) ? '0 : model[pad[9:0]];
        e_err = req && (pad >= DEP);
        if (req && we && pad < DEP) model[pad[9:0]] = merge(model[pad[9:0]], wd, be);
      end
    end

    // Reset in the middle of a fill: words 0..299 written, the rest untouched
    @(negedge clk);
    vga_en = 1; vga_addr = '0;
    fill_start = 1; fill_value = 16'h7777;
    repeat (301) begin
      @(negedge clk);
      fill_start = 0;
    end
    chk("busy_before_abort", 32'(fill_busy), 1);
    chk("vga_before_abort", 32'(vga_data), 32'h7777);
    rst_n = 0;
    #1 chk_all_zero("abort");
    for (int i = 0; i < 300; i++) model[i] = 16'h7777;
    @(negedge clk);
    rst_n = 1; vga_en = 0;
    @(negedge clk);
    ra[0] = 15'd299; ra[1] = 15'd300; ra[2] = 15'd0; ra[3] = 15'd301;
    for (int j = 0; j < 4; j++) begin
      proc_req = 1; proc_we = 0; proc_addr = ra[j];
      #1 chk($sformatf("abort_gnt%0d", j), 32'(proc_gnt), 1);
      @(negedge clk);
      chk($sformatf("abort_rdata_%0d", ra[j]), 32'(proc_rdata), 32'(model[ra[j][9:0]]));
    end
    proc_req = 0;
    chk("busy_after_abort", 32'(fill_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_proc_mem.md
# vga_proc_mem

Parametrised dual-port video/processor memory subsystem: a read-only display port and a read/write processor port share one inferred true dual-port block RAM. Adds byte-enable writes, valid/grant handshakes, out-of-range detection and a hardware fill engine (screen clear) that owns the processor port while running. It sits between the processor's data bus and the VGA scan-out controller as the frame/text buffer.

## Interface
- DATA_W, 16, word width; multiple of 8
- ADDR_W, 15, address width of both ports
- DEPTH, 2**ADDR_W, words implemented; DEPTH <= 2**ADDR_W
- BE_W, DATA_W/8, derived byte-enable width (not overridable)

- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous active-low reset
- vga_en  in  1  display read request
- vga_addr  in  ADDR_W  display read address
- vga_valid  out  1  vga_data valid this cycle
- vga_data  out  DATA_W  display read data
- proc_req  in  1  processor access request
- proc_we  in  1  1 = write, 0 = read
- proc_be  in  BE_W  byte enables for writes
- proc_addr  in  ADDR_W  processor address
- proc_wdata  in  DATA_W  processor write data
- proc_gnt  out  1  request accepted this cycle
- proc_rvalid  out  1  read response valid
- proc_rdata  out  DATA_W  read response data
- proc_err  out  1  out-of-range access flag, with rvalid (reads) or one cycle after grant (writes)
- fill_start  in  1  pulse: begin fill
- fill_value  in  DATA_W  fill word, sampled on fill_start
- fill_busy  out  1  fill engine active

## Operation
- Port A (display): read-only; vga_en in cycle N -> vga_data/vga_valid in N+1. Never stalls.
- Port B (processor): proc_gnt = proc_req & (state == IDLE), combinational. Granted write commits bytes where proc_be=1; bytes with be=0 unchanged. Granted read -> proc_rdata/proc_rvalid in N+1.
- Out of range (addr >= DEPTH; only possible when DEPTH < 2**ADDR_W): write dropped, read returns 0; proc_err pulses 1 cycle. Display reads out of range return 0, no error.
- Fill FSM: IDLE -> FILL on fill_start (ignored unless IDLE); counter starts at 0, writes fill_value (all bytes) to one word per cycle on port B; at counter == DEPTH-1 write last word -> IDLE. fill_busy = (state == FILL). proc_gnt held 0 during FILL; pending requests wait.
- fill_start and proc_req in same IDLE cycle: fill wins, request not granted.
- Same-address port A read and port B write in same cycle: see Configuration.
- Reset: all outputs 0, FSM IDLE, counter 0; RAM contents not cleared. Reset asserted mid-fill aborts; partially filled memory left as is.

## Timing
- Read latency 1 cycle on both ports; output data registered in RAM, valid flags registered.
- vga_data/proc_rdata hold last value when valid is low.
- Fill of DEPTH words takes exactly DEPTH cycles; fill_busy high DEPTH cycles starting the cycle after fill_start; first proc_gnt possible in cycle fill_start+DEPTH+1.
- Back-to-back granted requests every cycle supported; no bubbles.

## Configuration
- MEM_COLLISION_BYPASS_EN defined: same-cycle, same-address port B write and port A read -> vga_data returns newly written word (byte-merged with old data per proc_be/fill).
- Undefined: vga_data returns old contents (read-first); no bypass logic synthesised.

## Structure
- Package mem_pkg: fill FSM state enum (IDLE, FILL), default DATA_W/ADDR_W constants, BE_W derivation function.
- Sub-module dp_bram: inferred true dual-port RAM, port A read, port B byte-enable write/read, registered outputs, read-first on both ports. Top holds handshakes, range check, fill FSM and bypass.

## Test plan
- Write 0xBEEF to 0x0010 (be=11), read back -> proc_rvalid 1 cycle after grant, proc_rdata 0xBEEF, proc_err 0.
- Byte write 0x12xx, be=10 over 0xBEEF -> read returns 0x12EF.
- Parameter DEPTH=1024: read/write 0x0400 -> proc_err pulses, read data 0, memory at 0x0000 unchanged.
- fill_start with fill_value 0x0020, DEPTH=1024 -> fill_busy 1024 cycles, proc_req held meanwhile gets gnt in cycle 1025; VGA sweep reads 0x0020 everywhere.
- Same-address write 0xA5A5 / VGA read in one cycle -> vga_data 0xA5A5 with MEM_COLLISION_BYPASS_EN, old word without.
- rst_n low at fill word 300 -> all outputs 0, FSM IDLE, words 0..299 filled, word 300+ old contents, next proc_req granted immediately.
